dadda_mult_arbiter: RTL and testbench

Shares one combinational WIDTH-bit Dadda multiplier (dadda_6 class, reached through its if_multiplier-style operand/result signals) between NREQ requesters. Round-robin arbitration, registered operand launch, product capture and valid/ready response return to the granted requester. Sits between the requesting datapath units and the single multiplier instance.

---
 rtl/dadda_mult_arbiter_if.sv | 27 ++
 rtl/dadda_mult_arbiter.sv | 146 ++++++++++++++
 tb/tb_dadda_mult_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dadda_mult_arbiter_if.sv
// Request/response bundle between the requesting datapath units and the
// shared-multiplier arbiter. The master side is the requester/consumer
// population; the slave side is the arbiter.
interface dadda_mult_arbiter_if #(
    parameter int WIDTH = 6,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_prod;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod
    );
endinterface

// File: rtl/dadda_mult_arbiter.sv
// Round-robin arbiter sharing one combinational Dadda multiplier between
// NREQ requesters. One op in flight: grant (IDLE), settle (LAUNCH),
// capture product (CAPTURE), hold response until accepted (RESP).
// Optional: define MULT_ARB_ZERO_SKIP_EN to answer zero-operand requests
// directly from IDLE without using the multiplier.
module dadda_mult_arbiter #(
    parameter int WIDTH = 6,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    dadda_mult_arbiter_if.slave  bus,
    output logic [WIDTH-1:0]     mul_in1,
    output logic [WIDTH-1:0]     mul_in2,
    input  logic [WIDTH-1:0]     mul_out,
    input  logic [WIDTH-1:0]     mul_ovf
);

    typedef enum logic [1:0] {IDLE, LAUNCH, CAPTURE, RESP} state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [WIDTH-1:0]     in1_q, in1_d;
    logic [WIDTH-1:0]     in2_q, in2_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0]   rsp_prod_q, rsp_prod_d;
    logic [NREQ-1:0]      ready;

    logic                 found;
    logic [IDW-1:0]       win;
    logic [IDW-1:0]       win_next;
    logic [WIDTH-1:0]     win_a;
    logic [WIDTH-1:0]     win_b;

    // Round-robin pick: first valid requester at or after the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        logic [NREQ-1:0] sh;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        sh    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr_q) + i) % 32'(NREQ);
            sh  = bus.req_valid >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        win_next = IDW'((32'(win) + 32'd1) % 32'(NREQ));
        win_a    = WIDTH'(bus.req_a >> (32'(win) * 32'(WIDTH)));
        win_b    = WIDTH'(bus.req_b >> (32'(win) * 32'(WIDTH)));
    end

    // Next-state and registered-output logic for the single-op pipeline.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_prod_d  = rsp_prod_q;
        ready       = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    ready = NREQ'(1) << win;
                    ptr_d = win_next;
`ifdef MULT_ARB_ZERO_SKIP_EN
                    if (win_a == '0 || win_b == '0) begin
                        rsp_prod_d  = '0;
                        rsp_id_d    = win;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        in1_d   = win_a;
                        in2_d   = win_b;
                        id_d    = win;
                        state_d = LAUNCH;
                    end
`else
                    in1_d   = win_a;
                    in2_d   = win_b;
                    id_d    = win;
                    state_d = LAUNCH;
`endif
                end
            end
            LAUNCH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_prod_d  = {mul_ovf, mul_out};
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_prod_q  <= rsp_prod_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_prod  = rsp_prod_q;
    assign mul_in1       = in1_q;
    assign mul_in2       = in2_q;

endmodule

// File: tb/tb_dadda_mult_arbiter.sv
// Scoreboard bench for dadda_mult_arbiter: directed stimulus pushes expected
// responses; a negedge monitor checks grants, responses, latency and stability.
module tb_dadda_mult_arbiter;

    localparam int WIDTH = 6;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
`ifdef MULT_ARB_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [WIDTH-1:0] mul_in1, mul_in2, mul_out, mul_ovf;
    logic [2*WIDTH-1:0] mprod;

    dadda_mult_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

    dadda_mult_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .mul_in1 (mul_in1),
        .mul_in2 (mul_in2),
        .mul_out (mul_out),
        .mul_ovf (mul_ovf)
    );

    // Behavioural stand-in for the shared combinational multiplier.
    assign mprod   = {6'b0, mul_in1} * {6'b0, mul_in2};
    assign mul_out = mprod[5:0];
    assign mul_ovf = mprod[11:6];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int prod;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   gq_cyc[$];
    int   gq_vec[$];
    int   grant_cyc[$];
    int   nrsp = 0;
    int   nchk = 0;
    int   npass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic timeout(input string nm);
        nchk++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    function automatic void push(input int id, input int prod, input int lat);
        exp_t e;
        e.id = id; e.prod = prod; e.lat = lat;
        sb.push_back(e);
    endfunction

    // Monitor: grant bookkeeping, response compare, hold-stability under backpressure.
    logic       prev_valid = 1'b0;
    logic [1:0] hold_id;
    logic [11:0] hold_prod;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            gq_cyc.delete();
            gq_vec.delete();
            prev_valid = 1'b0;
        end else begin
            if (bus.req_ready != '0) begin
                check("grant_onehot", 32'($countones(bus.req_ready)), 1);
                gq_cyc.push_back(cyc);
                gq_vec.push_back(int'(bus.req_ready));
                grant_cyc.push_back(cyc);
            end
            if (bus.rsp_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(bus.rsp_id), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    check("rsp_prod", 32'(bus.rsp_prod), 32'(e.prod));
                    if (gq_cyc.size() == 0) begin
                        timeout("grant_missing");
                    end else begin
                        check("latency", 32'(cyc - gq_cyc.pop_front()), 32'(e.lat));
                        check("grant_vec", 32'(gq_vec.pop_front()), 32'(1) << e.id);
                    end
                end
                hold_id   = bus.rsp_id;
                hold_prod = bus.rsp_prod;
            end else if (bus.rsp_valid) begin
                check("hold_id", 32'(bus.rsp_id), 32'(hold_id));
                check("hold_prod", 32'(bus.rsp_prod), 32'(hold_prod));
            end
            if (bus.rsp_valid) check("ready_low_in_resp", 32'(bus.req_ready), 0);
            if (bus.rsp_valid && bus.rsp_ready) nrsp++;
            prev_valid = bus.rsp_valid && !bus.rsp_ready;
        end
    end

    task automatic set_op(input int k, input int a, input int b);
        bus.req_a[k*WIDTH +: WIDTH] = WIDTH'(a);
        bus.req_b[k*WIDTH +: WIDTH] = WIDTH'(b);
        bus.req_valid[k] = 1'b1;
    endtask

    // Wait for req_ready[k]; returns just after the accepting edge.
    task automatic wait_grant(input int k);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready[k]) got = 1;
        end
        if (!got) timeout($sformatf("grant%0d", k));
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 60 && nrsp < n; i++) @(posedge clk);
        if (nrsp < n) timeout("rsp_wait");
        #1;
    endtask

    initial begin
        int base;
        bit seen;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_id", 32'(bus.rsp_id), 0);
        check("rst_rsp_prod", 32'(bus.rsp_prod), 0);
        check("rst_mul_in1", 32'(mul_in1), 0);
        check("rst_mul_in2", 32'(mul_in2), 0);

        // Single op: 2*3.
        push(0, 6, 3);
        set_op(0, 2, 3);
        wait_grant(0);
        bus.req_valid = '0;
        wait_rsp(1);

        // Max operands and A*1 (pointer now 1, then 3).
        push(2, 3969, 3);
        set_op(2, 63, 63);
        wait_grant(2);
        bus.req_valid = '0;
        wait_rsp(2);
        push(3, 63, 3);
        set_op(3, 63, 1);
        wait_grant(3);
        bus.req_valid = '0;
        wait_rsp(3);

        // Fairness: all valid, pointer at 0 -> 0,1,2,3,0 every 4 cycles.
        push(0, 5, 3); push(1, 10, 3); push(2, 15, 3); push(3, 20, 3); push(0, 5, 3);
        base = grant_cyc.size();
        for (int k = 0; k < NREQ; k++) set_op(k, k + 1, 5);
        wait_grant(0); wait_grant(1); wait_grant(2); wait_grant(3); wait_grant(0);
        bus.req_valid = '0;
        wait_rsp(8);
        for (int i = 1; i < 5; i++)
            if (grant_cyc.size() > base + i)
                check("grant_spacing", 32'(grant_cyc[base+i] - grant_cyc[base+i-1]), 4);
            else timeout("grant_spacing");

        // Backpressure: 7*9 held for 6 extra cycles while requester 0 waits.
        bus.rsp_ready = 1'b0;
        push(1, 63, 3);
        push(0, 16, 3);
        set_op(1, 7, 9);
        wait_grant(1);
        bus.req_valid = '0;
        set_op(0, 4, 4);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        if (!seen) timeout("bp_rsp_valid");
        repeat (6) @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_grant(0);
        bus.req_valid = '0;
        wait_rsp(10);

        // Reset mid-op: pointer 1 picks requester 2; abort in LAUNCH.
        set_op(0, 3, 4);
        set_op(2, 5, 6);
        wait_grant(2);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("midrst_mul_in1", 32'(mul_in1), 0);
        check("midrst_mul_in2", 32'(mul_in2), 0);
        check("midrst_rsp_prod", 32'(bus.rsp_prod), 0);
        rst = 1'b0;
        push(0, 12, 3);
        push(2, 30, 3);
        wait_grant(0);
        bus.req_valid[0] = 1'b0;
        wait_grant(2);
        bus.req_valid = '0;
        wait_rsp(12);

        // Zero operand (pointer 3 -> requester 1 only).
        push(1, 0, ZLAT);
        set_op(1, 0, 37);
        wait_grant(1);
        bus.req_valid = '0;
        wait_rsp(13);

        repeat (4) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        check("rsp_count", 32'(nrsp), 13);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule
